// File: rtl/onehot_sel_pkg.sv
// rtl/onehot_sel_pkg.sv - shared types, constants and helpers for the one-hot select sequencer
package onehot_sel_pkg;

    // Default target count for the 3x3 matrix configuration.
    localparam int N_OUT_3X3 = 9;

    // Sequencer FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_e;

    // One bit of the one-hot code for index idx: true when bit position pos is the target.
    function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
        return (idx == pos);
    endfunction

endpackage

// File: rtl/onehot_select_sequencer_if.sv
// rtl/onehot_select_sequencer_if.sv - load-controller to select-sequencer handshake bundle
interface onehot_select_sequencer_if #(
    parameter int N_OUT = 9
);
    localparam int SEL_W = $clog2(N_OUT);

    logic             en;
    logic             mode;
    logic [SEL_W-1:0] addr;
    logic             addr_vld;
    logic             start;
    logic             step;
    logic [N_OUT-1:0] sel;
    logic [SEL_W-1:0] idx;
    logic             busy;
    logic             done;
    logic             err;

    // Load controller side: issues requests, observes the select fabric.
    modport master (
        output en, mode, addr, addr_vld, start, step,
        input  sel, idx, busy, done, err
    );

    // Sequencer side: consumes requests, drives the registered select.
    modport slave (
        input  en, mode, addr, addr_vld, start, step,
        output sel, idx, busy, done, err
    );

endinterface

// File: rtl/param_onehot_decoder.sv
// rtl/param_onehot_decoder.sv - combinational N-way one-hot decoder with range flag
module param_onehot_decoder
    import onehot_sel_pkg::*;
#(
    parameter int N_OUT = N_OUT_3X3,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic [SEL_W-1:0] idx,
    input  logic             en,
    output logic [N_OUT-1:0] onehot,
    output logic             oor
);

    logic in_range;

    // Range check is unsigned; for power-of-two N_OUT it is always in range.
    always_comb begin
        in_range = (32'(idx) < 32'(N_OUT));
        oor      = en && !in_range;
    end

    // Out-of-range or disabled indices decode to all-zero, never multi-hot.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_OUT; i++) begin
            onehot[i] = en && in_range && onehot_bit(32'(idx), i);
        end
    end

endmodule

// File: rtl/onehot_select_sequencer.sv
// rtl/onehot_select_sequencer.sv - registered one-hot select: direct decode or auto-sequence
module onehot_select_sequencer
    import onehot_sel_pkg::*;
#(
    parameter int N_OUT = N_OUT_3X3,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic clk,
    input  logic rst_n,
    onehot_select_sequencer_if.slave bus
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);

    state_e           state_q, state_d;
    logic [N_OUT-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0] dec_idx;
    logic             dec_en;
    logic [N_OUT-1:0] dec_onehot;
    logic             dec_oor;

    // Choose which index the shared decoder sees this cycle and whether sel may be driven.
    always_comb begin
        dec_idx = idx_q;
        dec_en  = 1'b0;
        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (bus.mode) begin
                        if (bus.start) begin
                            dec_idx = '0;
                            dec_en  = 1'b1;
                        end
                    end else if (bus.addr_vld) begin
                        dec_idx = bus.addr;
                        dec_en  = 1'b1;
                    end
                end
                SEQ: begin
                    if (bus.step) begin
                        // Last target accepted: sel drops to zero alongside done.
                        if (idx_q != LAST_IDX) begin
                            dec_idx = idx_q + 1'b1;
                            dec_en  = 1'b1;
                        end
                    end else begin
                        dec_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    param_onehot_decoder #(
        .N_OUT (N_OUT)
    ) u_decoder (
        .idx    (dec_idx),
        .en     (dec_en),
        .onehot (dec_onehot),
        .oor    (dec_oor)
    );

    // Next-state and next-output computation for the IDLE/SEQ sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (bus.mode) begin
                        if (bus.start) begin
                            state_d = SEQ;
                            idx_d   = '0;
                        end
                    end else if (bus.addr_vld) begin
                        if (dec_oor) begin
                            err_d = 1'b1;
                        end else begin
                            idx_d = bus.addr;
                        end
                    end
                end
                SEQ: begin
                    if (bus.step) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = IDLE;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        sel_d  = dec_onehot;
        busy_d = (state_d == SEQ);
    end

    // State and registered outputs; async reset aborts any sequence without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.sel  = sel_q;
    assign bus.idx  = idx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_onehot_select_sequencer.sv
// tb/tb_onehot_select_sequencer.sv - directed self-checking bench for onehot_select_sequencer
module tb_onehot_select_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    onehot_select_sequencer_if #(.N_OUT(9)) bus9 ();
    onehot_select_sequencer_if #(.N_OUT(5)) bus5 ();

    onehot_select_sequencer #(.N_OUT(9)) dut9 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus9)
    );

    onehot_select_sequencer #(.N_OUT(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus9.mode     = 1'b1;
        bus9.start    = 1'b1;
        bus9.addr_vld = 1'b1;
        bus9.en       = 1'b1;
        tick();
        tick();
        checks++;
        if (bus9.sel !== 9'h000) begin failures++; $display("FAIL reset_sel got=%h exp=000", bus9.sel); end
        checks++;
        if (bus9.idx !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus9.idx); end
        checks++;
        if ({bus9.busy, bus9.done, bus9.err} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {bus9.busy, bus9.done, bus9.err});
        end
        bus9.start    = 1'b0;
        bus9.addr_vld = 1'b0;
        bus9.mode     = 1'b0;
        rst_n         = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus9.sel, bus9.busy, bus9.done, bus9.err} !== 12'h000) begin
            failures++; $display("FAIL post_reset_quiet got=%h exp=000", {bus9.sel, bus9.busy, bus9.done, bus9.err});
        end
    endtask

    task automatic test_direct();
        bus9.mode     = 1'b0;
        bus9.addr     = 4'd5;
        bus9.addr_vld = 1'b1;
        tick();
        bus9.addr_vld = 1'b0;
        checks++;
        if (bus9.sel !== 9'h020) begin failures++; $display("FAIL direct5_sel got=%h exp=020", bus9.sel); end
        checks++;
        if (bus9.idx !== 4'd5) begin failures++; $display("FAIL direct5_idx got=%0d exp=5", bus9.idx); end
        checks++;
        if (bus9.err !== 1'b0) begin failures++; $display("FAIL direct5_err got=%b exp=0", bus9.err); end
        tick();
        checks++;
        if (bus9.sel !== 9'h000) begin failures++; $display("FAIL direct_pulse got=%h exp=000", bus9.sel); end
        bus9.addr     = 4'd9;
        bus9.addr_vld = 1'b1;
        tick();
        bus9.addr_vld = 1'b0;
        checks++;
        if (bus9.sel !== 9'h000) begin failures++; $display("FAIL direct9_sel got=%h exp=000", bus9.sel); end
        checks++;
        if (bus9.err !== 1'b1) begin failures++; $display("FAIL direct9_err got=%b exp=1", bus9.err); end
        checks++;
        if (bus9.idx !== 4'd5) begin failures++; $display("FAIL direct9_idx got=%0d exp=5", bus9.idx); end
        tick();
        checks++;
        if (bus9.err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", bus9.err); end
        bus9.addr     = 4'd8;
        bus9.addr_vld = 1'b1;
        tick();
        bus9.addr_vld = 1'b0;
        checks++;
        if (bus9.sel !== 9'h100) begin failures++; $display("FAIL direct8_sel got=%h exp=100", bus9.sel); end
        bus9.addr     = 4'd0;
        bus9.addr_vld = 1'b1;
        tick();
        bus9.addr_vld = 1'b0;
        checks++;
        if (bus9.sel !== 9'h001 || bus9.idx !== 4'd0) begin
            failures++; $display("FAIL direct0 got sel=%h idx=%0d exp sel=001 idx=0", bus9.sel, bus9.idx);
        end
        tick();
    endtask

    task automatic test_sequence();
        logic [8:0] walk [9];
        walk = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h080, 9'h100};
        bus9.mode  = 1'b1;
        bus9.start = 1'b1;
        tick();
        bus9.start = 1'b0;
        bus9.step  = 1'b1;
        checks++;
        if (bus9.busy !== 1'b1) begin failures++; $display("FAIL seq_busy got=%b exp=1", bus9.busy); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (bus9.sel !== walk[i] || bus9.idx !== 4'(i)) begin
                failures++; $display("FAIL seq_walk%0d got sel=%h idx=%0d exp sel=%h idx=%0d", i, bus9.sel, bus9.idx, walk[i], i);
            end
            tick();
        end
        checks++;
        if ({bus9.sel, bus9.done, bus9.busy, bus9.idx} !== {9'h000, 1'b1, 1'b0, 4'd0}) begin
            failures++; $display("FAIL seq_done got sel=%h done=%b busy=%b idx=%0d exp 000/1/0/0", bus9.sel, bus9.done, bus9.busy, bus9.idx);
        end
        bus9.step = 1'b0;
        tick();
        checks++;
        if (bus9.done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b exp=0", bus9.done); end
    endtask

    task automatic test_stall_pause();
        int n;
        bus9.mode  = 1'b1;
        bus9.start = 1'b1;
        tick();
        bus9.start = 1'b0;
        bus9.step  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus9.step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus9.sel !== 9'h010 || bus9.idx !== 4'd4) begin
                failures++; $display("FAIL stall%0d got sel=%h idx=%0d exp sel=010 idx=4", i, bus9.sel, bus9.idx);
            end
            tick();
        end
        bus9.en   = 1'b0;
        bus9.step = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus9.sel !== 9'h000 || bus9.idx !== 4'd4 || bus9.busy !== 1'b1) begin
                failures++; $display("FAIL pause%0d got sel=%h idx=%0d busy=%b exp sel=000 idx=4 busy=1", i, bus9.sel, bus9.idx, bus9.busy);
            end
        end
        bus9.en   = 1'b1;
        bus9.step = 1'b0;
        tick();
        checks++;
        if (bus9.sel !== 9'h010 || bus9.idx !== 4'd4) begin
            failures++; $display("FAIL resume got sel=%h idx=%0d exp sel=010 idx=4", bus9.sel, bus9.idx);
        end
        bus9.step = 1'b1;
        n = 0;
        while (bus9.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        bus9.step = 1'b0;
        checks++;
        if (n !== 5) begin failures++; $display("FAIL stall_remaining_accepts got=%0d exp=5", n); end
        tick();
    endtask

    task automatic test_abort_retrigger();
        bus9.mode  = 1'b1;
        bus9.start = 1'b1;
        tick();
        bus9.start = 1'b0;
        bus9.step  = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (bus9.idx !== 4'd6) begin failures++; $display("FAIL abort_pre_idx got=%0d exp=6", bus9.idx); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus9.sel, bus9.idx, bus9.busy, bus9.done, bus9.err} !== 16'h0000) begin
            failures++; $display("FAIL async_abort got sel=%h idx=%0d busy=%b done=%b err=%b exp all 0", bus9.sel, bus9.idx, bus9.busy, bus9.done, bus9.err);
        end
        bus9.step = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus9.done !== 1'b0 || bus9.busy !== 1'b0) begin
            failures++; $display("FAIL abort_no_done got done=%b busy=%b exp 0/0", bus9.done, bus9.busy);
        end
        bus9.start = 1'b1;
        tick();
        bus9.start = 1'b0;
        bus9.step  = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (bus9.done !== 1'b1) begin failures++; $display("FAIL retrig_first_done got=%b exp=1", bus9.done); end
        bus9.start = 1'b1;
        tick();
        bus9.start = 1'b0;
        bus9.step  = 1'b0;
        checks++;
        if (bus9.sel !== 9'h001 || bus9.busy !== 1'b1 || bus9.done !== 1'b0) begin
            failures++; $display("FAIL back_to_back got sel=%h busy=%b done=%b exp 001/1/0", bus9.sel, bus9.busy, bus9.done);
        end
        bus9.step = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        bus9.step = 1'b0;
        checks++;
        if (bus9.done !== 1'b1) begin failures++; $display("FAIL retrig_second_done got=%b exp=1", bus9.done); end
        tick();
    endtask

    task automatic test_nonpow2();
        logic [4:0] walk [5];
        walk = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10};
        bus5.en   = 1'b1;
        bus5.mode = 1'b0;
        for (int a = 5; a < 8; a++) begin
            bus5.addr     = 3'(a);
            bus5.addr_vld = 1'b1;
            tick();
            bus5.addr_vld = 1'b0;
            checks++;
            if (bus5.err !== 1'b1 || bus5.sel !== 5'h00) begin
                failures++; $display("FAIL n5_oor%0d got err=%b sel=%h exp err=1 sel=00", a, bus5.err, bus5.sel);
            end
        end
        bus5.addr     = 3'd4;
        bus5.addr_vld = 1'b1;
        tick();
        bus5.addr_vld = 1'b0;
        checks++;
        if (bus5.sel !== 5'h10 || bus5.err !== 1'b0 || bus5.idx !== 3'd4) begin
            failures++; $display("FAIL n5_direct4 got sel=%h err=%b idx=%0d exp 10/0/4", bus5.sel, bus5.err, bus5.idx);
        end
        bus5.mode  = 1'b1;
        bus5.start = 1'b1;
        tick();
        bus5.start = 1'b0;
        bus5.step  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus5.sel !== walk[i] || bus5.idx !== 3'(i)) begin
                failures++; $display("FAIL n5_walk%0d got sel=%h idx=%0d exp sel=%h idx=%0d", i, bus5.sel, bus5.idx, walk[i], i);
            end
            tick();
        end
        bus5.step = 1'b0;
        checks++;
        if ({bus5.sel, bus5.done, bus5.busy, bus5.idx, bus5.err} !== {5'h00, 1'b1, 1'b0, 3'd0, 1'b0}) begin
            failures++; $display("FAIL n5_done got sel=%h done=%b busy=%b idx=%0d err=%b exp 00/1/0/0/0", bus5.sel, bus5.done, bus5.busy, bus5.idx, bus5.err);
        end
        tick();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus9.en       = 1'b0;
        bus9.mode     = 1'b0;
        bus9.addr     = '0;
        bus9.addr_vld = 1'b0;
        bus9.start    = 1'b0;
        bus9.step     = 1'b0;
        bus5.en       = 1'b0;
        bus5.mode     = 1'b0;
        bus5.addr     = '0;
        bus5.addr_vld = 1'b0;
        bus5.start    = 1'b0;
        bus5.step     = 1'b0;
        test_reset();
        test_direct();
        test_sequence();
        test_stall_pause();
        test_abort_retrigger();
        test_nonpow2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onehot_select_sequencer.md
# onehot_select_sequencer

Parametrised, registered one-hot select generator for the matrix-multiplication accelerator's element/PE write-enable fabric. Replaces the fixed 9-way combinational decoder with an N-way block that decodes a direct address with range checking, or autonomously sequences through all N targets under a step handshake. It sits between the load controller and the operand register bank and drives one write enable per matrix element.

## Interface
- N_OUT, 9, number of one-hot targets (≥2); 9 = 3×3 matrix
- SEL_W, $clog2(N_OUT), index width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  global enable; low forces sel to 0 and pauses sequencing
- mode  in  1  0 = direct decode, 1 = auto-sequence
- addr  in  SEL_W  direct-mode target index
- addr_vld  in  1  direct-mode request strobe
- start  in  1  begin a sequence (mode=1)
- step  in  1  consumer accepted current target; advance
- sel  out  N_OUT  registered one-hot (or all-zero) select
- idx  out  SEL_W  index of current target
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse after last target accepted
- err  out  1  one-cycle pulse on out-of-range direct address

## Operation
- FSM states: IDLE, SEQ. Reset state IDLE.
- IDLE, mode=0, en=1, addr_vld=1: if addr < N_OUT, next cycle sel = 1<<addr, idx = addr; else sel = 0, err = 1, idx unchanged. sel is a single-cycle pulse per addr_vld; no addr_vld -> sel = 0.
- IDLE, mode=1, en=1, start=1: go SEQ, busy=1, idx=0, sel=1<<0 next cycle. addr_vld in the same cycle ignored (start wins).
- SEQ: sel = 1<<idx held while step=0. step=1 & en=1 at an edge: if idx < N_OUT-1, idx+1; if idx = N_OUT-1, go IDLE, sel=0, busy=0, done=1 for one cycle, idx returns to 0.
- SEQ, en=0: sel = 0 next cycle, idx/state held, step ignored; en returning high restores sel = 1<<idx next cycle.
- SEQ: start, addr_vld, mode changes ignored; no err generated.
- IDLE, en=0: all strobes ignored, sel = 0.
- Invariant: sel is one-hot or zero; never multi-hot. sel nonzero ⇒ sel == 1<<idx.
- Arithmetic: range compare addr < N_OUT unsigned at SEL_W bits; idx increment never exceeds N_OUT-1 (no wrap-around counting through unused codes when N_OUT is not a power of two).

## Timing
- Reset values: sel=0, idx=0, busy=0, done=0, err=0, state IDLE. Async assertion mid-sequence aborts immediately; no done pulse.
- Direct decode latency: 1 cycle (addr_vld edge k -> sel/err valid cycle k+1).
- Sequence: start at edge k -> sel[0] in k+1. Target i accepted on the edge where sel[i]=1 and step=1. Continuous step: N_OUT cycles of sel, done in cycle k+N_OUT+1 coinciding with sel=0.
- Back-to-back: start accepted in the cycle done is high (state already IDLE).
- done and err never high together; all outputs registered, no combinational input->output paths.

## Structure
- Package onehot_sel_pkg: FSM state enum (IDLE, SEQ), function for one-hot of an index, shared N_OUT default constant for the 3×3 configuration.
- Sub-module param_onehot_decoder: combinational, parameter N_OUT, inputs index + enable, outputs N_OUT one-hot and out-of-range flag; instantiated once, its output registered in the top.

## Test plan
- Reset: hold rst_n low, drive start/addr_vld -> all outputs 0; release, no activity until a strobe.
- Direct: N_OUT=9, addr=5, addr_vld one cycle -> next cycle sel=9'h020, idx=5; addr=9 -> sel=0, err=1 one cycle, idx still 5.
- Sequence with continuous step: start then step=1 -> sel walks 0x001…0x100 over 9 cycles, then done=1, busy=0, sel=0.
- Stall/pause: step low 3 cycles at idx=4 -> sel=0x010 held; en low 2 cycles -> sel=0, idx=4 held; en high -> sel=0x010 restored, sequence completes with exactly 9 accepted targets.
- Abort and retrigger: rst_n low at idx=6 -> all outputs 0 asynchronously, no done; start in done cycle of a prior run -> new sequence sel[0] next cycle.
- Non-power-of-two check: N_OUT=5, addr=5,6,7 -> err each; sequence ends at idx=4 with done, never reaches idx 5.
